wdt_escalation_ctrl: RTL and testbench
======================================

# wdt_escalation_ctrl

Sequencing controller that sits above the watchdog timebase and decides when a missed heartbeat becomes a system fault. Consumes a single tick pulse (normally the msec pulse of the shared timer), aggregates heartbeats from several software/hardware requesters, and enforces a service window. On a missed service it escalates in two stages: warning interrupt, then latched bite (reset request).

## Interface
- CNT_W, 10: width of all tick counters and configuration thresholds
- N_SRC, 4: number of heartbeat requesters
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick  in  1  single-cycle timebase pulse
- enable  in  1  arm request; level
- lock_set  in  1  pulse; sets sticky lock, cleared only by rst
- src_mask  in  N_SRC  requesters that must kick each service period
- kick  in  N_SRC  per-requester heartbeat pulses
- timeout_ticks  in  CNT_W  ticks allowed in ARMED before WARN
- warn_ticks  in  CNT_W  ticks allowed in WARN before BITE
- window_min  in  CNT_W  earliest tick count at which a service is legal
- state  out  2  current state encoding
- count  out  CNT_W  current tick count
- warn_irq  out  1  high while in WARN
- bite  out  1  latched fault; high in BITE
- early_err  out  1  sticky; set on service before window_min
- locked  out  1  current lock status

## Operation
- States: DISABLED=0, ARMED=1, WARN=2, BITE=3.
- DISABLED -> ARMED when enable=1. On that transition, timeout_ticks, warn_ticks, window_min and src_mask are captured into shadow registers; all later comparisons use shadows. count=0; pending=0.
- Kick aggregation: pending_nxt = pending | (kick & mask_shadow). Service occurs when mask_shadow != 0 and (pending_nxt & mask_shadow) == mask_shadow. On service, pending clears to 0; kicks in the service cycle are consumed. With mask_shadow = 0, service never occurs.
- ARMED:
  - Service with count >= window_min: count=0, stay in ARMED.
  - Service with count < window_min: early_err=1, go to BITE.
  - Otherwise each tick increments count. When the incremented value equals max(timeout_ticks, 1): go to WARN, count=0.
- WARN:
  - Service, with no window check: go to ARMED, count=0.
  - Otherwise ticks increment count. Reaching max(warn_ticks, 1) sends the block to BITE.
- BITE is terminal until rst. Kicks, enable and lock_set are ignored. count freezes.
- enable=0 in ARMED or WARN: go to DISABLED only if locked=0. If locked=1, enable=0 is ignored.
- lock_set is accepted in any state except BITE.
- Simultaneous events:
  - Service and tick in the same cycle: service wins. count becomes 0, not 1.
  - Service and disable in the same cycle (unlocked): disable wins.
  - Timeout and service in the same cycle: service wins.
- count saturates; it never wraps.

## Timing
- All outputs are registered and change on the clk edge after the causing input cycle (1-cycle latency).
- warn_irq = (state==WARN). bite = (state==BITE). Both derive from the registered state with no extra flop delay.
- Reset values: state=DISABLED, count=0, warn_irq=0, bite=0, early_err=0, locked=0, pending=0, shadows=0.
- rst mid-operation, including in BITE: everything returns to reset values on the next edge.
- Input and timing rules:
  - tick must be a single-cycle pulse. Back-to-back ticks on consecutive cycles each count.
  - kick is sampled every cycle. Holding a bit high counts as repeated kicks.

## Structure
- Package wdt_pkg holds:
  - the state typedef (2-bit enum, encodings above)
  - default CNT_W and N_SRC
  - the constant used for max(x, 1) threshold clamping
- Sub-module wdt_kick_collector owns pending, mask_shadow and the service detect.
  - Ports: clk, rst, clear, capture, src_mask, kick; output service.
- The top contains the FSM, counters, shadows and lock.

## Test plan
- Normal service: timeout=10, window=3, mask=4'b0011. Kick src0 at count 4 and src1 at count 5 -> count returns to 0 the cycle after src1, state stays ARMED, early_err=0.
- Escalation: timeout=5, warn=3, no kicks -> WARN on the 5th tick (warn_irq=1), BITE on the 3rd tick after that. bite stays 1 after subsequent kicks and enable=0. rst clears all outputs.
- Early kick: window=4. Both masked sources kick at count 2 -> early_err=1 and state=BITE on the next edge.
- Recovery from WARN: full service at WARN count 1 -> state=ARMED, count=0, warn_irq=0.
- Lock: lock_set, then enable=0 -> state stays ARMED. Without lock, enable=0 -> DISABLED. Changing timeout_ticks while ARMED has no effect until the next arm.
- Corner cases:
  - timeout_ticks=0 behaves as 1.
  - mask=0 never services and reaches BITE.
  - Tick coincident with the completing kick leaves count=0.

Source files
------------

// File: rtl/wdt_pkg.sv
// Shared types and constants for the watchdog escalation controller.
package wdt_pkg;

  localparam int unsigned CNT_W_DEF = 10;
  localparam int unsigned N_SRC_DEF = 4;

  // Thresholds of zero are treated as this value so a stage always lasts a tick.
  localparam int unsigned THR_MIN = 1;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_WARN     = 2'd2,
    ST_BITE     = 2'd3
  } wdt_state_e;

endpackage

// File: rtl/wdt_kick_collector.sv
// Accumulates masked heartbeats and flags a service once every required source kicked.
module wdt_kick_collector
  import wdt_pkg::*;
#(
  parameter int unsigned N_SRC = N_SRC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             capture,
  input  logic [N_SRC-1:0] src_mask,
  input  logic [N_SRC-1:0] kick,
  output logic             service
);

  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] pending_nxt;

  // Service detect; kicks in the service cycle are consumed with the clear.
  always_comb begin
    pending_nxt = pending_q | (kick & mask_q);
    service     = (mask_q != '0) && ((pending_nxt & mask_q) == mask_q);
    mask_d      = mask_q;
    pending_d   = pending_nxt;
    if (capture) begin
      mask_d    = src_mask;
      pending_d = '0;
    end else if (clear || service) begin
      pending_d = '0;
    end
  end

  // Pending and mask shadow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

endmodule

// File: rtl/wdt_escalation_ctrl.sv
// Watchdog sequencer: service window, warning stage, then latched bite.
module wdt_escalation_ctrl
  import wdt_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned N_SRC = N_SRC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             enable,
  input  logic             lock_set,
  input  logic [N_SRC-1:0] src_mask,
  input  logic [N_SRC-1:0] kick,
  input  logic [CNT_W-1:0] timeout_ticks,
  input  logic [CNT_W-1:0] warn_ticks,
  input  logic [CNT_W-1:0] window_min,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] count,
  output logic             warn_irq,
  output logic             bite,
  output logic             early_err,
  output logic             locked
);

  wdt_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] to_q, to_d, wn_q, wn_d, win_q, win_d;
  logic             early_q, early_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] inc, thr_to, thr_wn;
  logic             service, clear, capture, disable_req;

  // Thresholds clamped to at least one tick; increment saturates.
  assign thr_to      = (to_q == '0) ? CNT_W'(THR_MIN) : to_q;
  assign thr_wn      = (wn_q == '0) ? CNT_W'(THR_MIN) : wn_q;
  assign inc         = (count_q == '1) ? count_q : count_q + CNT_W'(1);
  assign disable_req = !enable && !locked_q;
  assign capture     = (state_q == ST_DISABLED) && enable;
  assign clear       = (state_q == ST_DISABLED) || (state_q == ST_BITE) || disable_req;

  wdt_kick_collector #(.N_SRC(N_SRC)) u_collector (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .capture  (capture),
    .src_mask (src_mask),
    .kick     (kick),
    .service  (service)
  );

  // Next-state, counter, shadow and lock logic.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    to_d     = to_q;
    wn_d     = wn_q;
    win_d    = win_q;
    early_d  = early_q;
    locked_d = locked_q | (lock_set && (state_q != ST_BITE));
    case (state_q)
      ST_DISABLED: begin
        count_d = '0;
        if (enable) begin
          state_d = ST_ARMED;
          to_d    = timeout_ticks;
          wn_d    = warn_ticks;
          win_d   = window_min;
        end
      end
      ST_ARMED: begin
        if (disable_req) begin
          state_d = ST_DISABLED;
          count_d = '0;
        end else if (service) begin
          if (count_q >= win_q) begin
            count_d = '0;
          end else begin
            early_d = 1'b1;
            state_d = ST_BITE;
          end
        end else if (tick) begin
          if (inc == thr_to) begin
            state_d = ST_WARN;
            count_d = '0;
          end else begin
            count_d = inc;
          end
        end
      end
      ST_WARN: begin
        if (disable_req) begin
          state_d = ST_DISABLED;
          count_d = '0;
        end else if (service) begin
          state_d = ST_ARMED;
          count_d = '0;
        end else if (tick) begin
          count_d = inc;
          if (inc == thr_wn) begin
            state_d = ST_BITE;
          end
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_DISABLED;
      count_q  <= '0;
      to_q     <= '0;
      wn_q     <= '0;
      win_q    <= '0;
      early_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      to_q     <= to_d;
      wn_q     <= wn_d;
      win_q    <= win_d;
      early_q  <= early_d;
      locked_q <= locked_d;
    end
  end

  assign state     = state_q;
  assign count     = count_q;
  assign warn_irq  = (state_q == ST_WARN);
  assign bite      = (state_q == ST_BITE);
  assign early_err = early_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_wdt_escalation_ctrl.sv
// Self-checking bench: directed vector table, corner sequences, randomized model compare.
module tb_wdt_escalation_ctrl;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned N_SRC = 4;
  localparam int CMAX = 1023;
  localparam int M_DIS = 0, M_ARM = 1, M_WRN = 2, M_BIT = 3;

  logic clk = 1'b0;
  logic rst, tick, enable, lock_set;
  logic [N_SRC-1:0] src_mask, kick;
  logic [CNT_W-1:0] timeout_ticks, warn_ticks, window_min;
  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic warn_irq, bite, early_err, locked;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model variables.
  int m_st, m_cnt, m_pend, s_to, s_wn, s_win, s_mask;
  bit m_er, m_lk;

  wdt_escalation_ctrl #(.CNT_W(CNT_W), .N_SRC(N_SRC)) dut (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable), .lock_set(lock_set),
    .src_mask(src_mask), .kick(kick), .timeout_ticks(timeout_ticks),
    .warn_ticks(warn_ticks), .window_min(window_min), .state(state),
    .count(count), .warn_irq(warn_irq), .bite(bite), .early_err(early_err),
    .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model of one clock: applies the rules to the current inputs.
  task automatic model_step();
    int thr, c, pn;
    bit svc, lk;
    if (rst) begin
      m_st = M_DIS; m_cnt = 0; m_er = 0; m_lk = 0; m_pend = 0;
      s_to = 0; s_wn = 0; s_win = 0; s_mask = 0;
      return;
    end
    lk = m_lk || (lock_set && m_st != M_BIT);
    if (m_st == M_DIS) begin
      m_cnt = 0;
      if (enable) begin
        m_st = M_ARM; m_pend = 0;
        s_to = int'(timeout_ticks); s_wn = int'(warn_ticks);
        s_win = int'(window_min); s_mask = int'(src_mask);
      end
    end else if (m_st == M_ARM || m_st == M_WRN) begin
      pn  = m_pend | (int'(kick) & s_mask);
      svc = (s_mask != 0) && ((pn & s_mask) == s_mask);
      c   = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
      if (!enable && !m_lk) begin
        m_st = M_DIS; m_cnt = 0; m_pend = 0;
      end else if (svc) begin
        m_pend = 0;
        if (m_st == M_WRN) begin
          m_st = M_ARM; m_cnt = 0;
        end else if (m_cnt >= s_win) begin
          m_cnt = 0;
        end else begin
          m_er = 1; m_st = M_BIT;
        end
      end else begin
        m_pend = pn;
        if (tick) begin
          thr = (m_st == M_ARM) ? ((s_to < 1) ? 1 : s_to) : ((s_wn < 1) ? 1 : s_wn);
          if (c == thr) begin
            m_cnt = (m_st == M_ARM) ? 0 : c;
            m_st  = (m_st == M_ARM) ? M_WRN : M_BIT;
          end else begin
            m_cnt = c;
          end
        end
      end
    end
    m_lk = lk;
  endtask

  // Advance one clock and compare every output against the model.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("state", int'(state), m_st);
    chk("count", int'(count), m_cnt);
    chk("warn_irq", int'(warn_irq), int'(m_st == M_WRN));
    chk("bite", int'(bite), int'(m_st == M_BIT));
    chk("early_err", int'(early_err), int'(m_er));
    chk("locked", int'(locked), int'(m_lk));
  endtask

  task automatic idle_inputs();
    rst = 0; tick = 0; enable = 0; lock_set = 0; kick = '0;
  endtask

  task automatic cfg(input int to, input int wn, input int win, input int msk);
    timeout_ticks = CNT_W'(to); warn_ticks = CNT_W'(wn);
    window_min = CNT_W'(win); src_mask = N_SRC'(msk);
  endtask

  task automatic do_reset();
    idle_inputs(); rst = 1; cyc(); rst = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1; cyc();
    end
    tick = 0;
  endtask

  typedef struct {
    bit       r;
    bit       en;
    bit       tk;
    bit [3:0] kk;
    int       st;
    int       cnt;
    bit       er;
  } vec_t;

  vec_t vt[16];

  initial begin
    idle_inputs();
    rst = 1;
    cfg(0, 0, 0, 0);

    // Normal service, service-with-tick, window boundary, early kick, BITE hold, rst.
    vt[0]  = '{1, 0, 0, 4'h0, 0, 0, 0};
    vt[1]  = '{0, 1, 0, 4'h0, 1, 0, 0};
    vt[2]  = '{0, 1, 1, 4'h0, 1, 1, 0};
    vt[3]  = '{0, 1, 1, 4'h0, 1, 2, 0};
    vt[4]  = '{0, 1, 1, 4'h0, 1, 3, 0};
    vt[5]  = '{0, 1, 1, 4'h0, 1, 4, 0};
    vt[6]  = '{0, 1, 0, 4'h1, 1, 4, 0};
    vt[7]  = '{0, 1, 1, 4'h0, 1, 5, 0};
    vt[8]  = '{0, 1, 0, 4'h2, 1, 0, 0};
    vt[9]  = '{0, 1, 1, 4'h0, 1, 1, 0};
    vt[10] = '{0, 1, 1, 4'h0, 1, 2, 0};
    vt[11] = '{0, 1, 1, 4'h0, 1, 3, 0};
    vt[12] = '{0, 1, 1, 4'h3, 1, 0, 0};
    vt[13] = '{0, 1, 0, 4'h3, 3, 0, 1};
    vt[14] = '{0, 0, 1, 4'h3, 3, 0, 1};
    vt[15] = '{1, 0, 0, 4'h0, 0, 0, 0};

    cfg(10, 3, 3, 4'b0011);
    for (int i = 0; i < 16; i++) begin
      rst = vt[i].r; enable = vt[i].en; tick = vt[i].tk; kick = vt[i].kk;
      cyc();
      chk($sformatf("vec%0d_state", i), int'(state), vt[i].st);
      chk($sformatf("vec%0d_count", i), int'(count), vt[i].cnt);
      chk($sformatf("vec%0d_early", i), int'(early_err), int'(vt[i].er));
    end
    idle_inputs();

    // Escalation: WARN on 5th tick, BITE on 3rd tick after, BITE holds, rst clears.
    do_reset();
    cfg(5, 3, 0, 4'b0001);
    enable = 1; cyc();
    ticks(4);
    chk("esc_pre_warn", int'(state), M_ARM);
    ticks(1);
    chk("esc_warn_irq", int'(warn_irq), 1);
    ticks(2);
    chk("esc_pre_bite", int'(state), M_WRN);
    ticks(1);
    chk("esc_bite", int'(bite), 1);
    kick = 4'hF; cyc(); enable = 0; lock_set = 1; cyc(); kick = '0; lock_set = 0;
    chk("esc_bite_hold", int'(bite), 1);
    chk("esc_lock_ignored", int'(locked), 0);
    do_reset();
    chk("rst_bite", int'(bite), 0);
    chk("rst_early", int'(early_err), 0);

    // Early kick with window=4 at count 2.
    cfg(10, 3, 4, 4'b0011);
    enable = 1; cyc();
    ticks(2);
    kick = 4'b0011; cyc(); kick = '0;
    chk("early_err", int'(early_err), 1);
    chk("early_bite", int'(state), M_BIT);
    do_reset();

    // Recovery from WARN at count 1.
    cfg(2, 5, 0, 4'b0011);
    enable = 1; cyc();
    ticks(3);
    chk("rec_warn_cnt", int'(count), 1);
    kick = 4'b0011; cyc(); kick = '0;
    chk("rec_state", int'(state), M_ARM);
    chk("rec_irq", int'(warn_irq), 0);
    do_reset();

    // Lock holds ARMED with enable=0; shadowed timeout ignores live changes.
    cfg(3, 2, 0, 4'b0001);
    enable = 1; cyc();
    lock_set = 1; cyc(); lock_set = 0;
    enable = 0; cyc(); cyc();
    chk("lock_hold", int'(state), M_ARM);
    timeout_ticks = CNT_W'(9);
    ticks(3);
    chk("shadow_to", int'(state), M_WRN);
    do_reset();
    enable = 1; cyc(); enable = 0; cyc();
    chk("unlock_dis", int'(state), M_DIS);

    // timeout_ticks=0 acts as one tick.
    cfg(0, 4, 0, 4'b0001);
    enable = 1; cyc();
    ticks(1);
    chk("to_zero", int'(state), M_WRN);
    do_reset();

    // mask=0 never services.
    cfg(2, 2, 0, 4'b0000);
    enable = 1; kick = 4'hF; cyc();
    ticks(4);
    chk("mask0_bite", int'(state), M_BIT);
    do_reset();

    // Randomized run against the model, live config changing every cycle.
    for (int i = 0; i < 4000; i++) begin
      rst           = ($urandom_range(0, 249) == 0);
      enable        = ($urandom_range(0, 11) != 0);
      tick          = 1'($urandom_range(0, 1));
      kick          = ($urandom_range(0, 2) == 0) ? N_SRC'($urandom_range(0, 15)) : '0;
      lock_set      = ($urandom_range(0, 149) == 0);
      timeout_ticks = CNT_W'($urandom_range(0, 6));
      warn_ticks    = CNT_W'($urandom_range(0, 5));
      window_min    = CNT_W'($urandom_range(0, 4));
      src_mask      = N_SRC'($urandom_range(0, 15));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
